// File: rtl/vga_pixel_rgb_resampler_if.sv
// Avalon-ST pixel stream bundle: RGB565 sink side and RGB888 source side.
// The resampler takes the slave modport and the upstream/downstream driver takes master.
interface vga_pixel_rgb_resampler_if;
   logic [15:0] sink_data;
   logic        sink_startofpacket;
   logic        sink_endofpacket;
   logic        sink_valid;
   logic        sink_ready;
   logic [23:0] source_data;
   logic        source_startofpacket;
   logic        source_endofpacket;
   logic        source_valid;
   logic        source_ready;

   modport slave (
      input  sink_data, sink_startofpacket, sink_endofpacket, sink_valid,
      output sink_ready,
      output source_data, source_startofpacket, source_endofpacket, source_valid,
      input  source_ready
   );

   modport master (
      output sink_data, sink_startofpacket, sink_endofpacket, sink_valid,
      input  sink_ready,
      input  source_data, source_startofpacket, source_endofpacket, source_valid,
      output source_ready
   );
endinterface

// File: rtl/vga_pixel_rgb_resampler.sv
// RGB565 -> RGB888 expander with a show-ahead FIFO and a frame-framing checker.
// Beats that arrive outside a frame are dropped; framing faults raise a sticky flag.
module vga_pixel_rgb_resampler #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          sys_clk_clk,
   input  logic                          sys_reset_reset,
   vga_pixel_rgb_resampler_if.slave      st,
   output logic [15:0]                   frame_count,
   output logic                          frame_err,
   input  logic                          clear_err
);
   localparam int N  = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int CW = $clog2(N + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] N_C     = CW'(N);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   pix_cnt, pix_cnt_next, pix_inc;
   logic [25:0]     mem [FIFO_DEPTH];
   logic [25:0]     head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     fifo_count;
   logic [23:0]     rgb;
   logic            accept, push, pop, write_beat, err_set, frame_done;

   assign st.sink_ready = !sys_reset_reset && (fifo_count < DEPTH_C);
   assign accept        = st.sink_valid && st.sink_ready;
   assign push          = accept && write_beat;
   assign pop           = st.source_valid && st.source_ready;
   assign pix_inc       = pix_cnt + ONE_C;

   // Bit replication fills the low bits so full-scale 5/6-bit values map to 0xFF.
   assign rgb = {st.sink_data[15:11], st.sink_data[15:13],
                 st.sink_data[10:5],  st.sink_data[10:9],
                 st.sink_data[4:0],   st.sink_data[4:2]};

   assign head                    = mem[rd_ptr];
   assign st.source_valid         = (fifo_count != '0);
   assign st.source_data          = st.source_valid ? head[25:2] : '0;
   assign st.source_startofpacket = st.source_valid && head[1];
   assign st.source_endofpacket   = st.source_valid && head[0];

   // Framing decisions are taken only on accepted beats.
   always_comb begin
      state_next   = state;
      pix_cnt_next = pix_cnt;
      write_beat   = 1'b0;
      err_set      = 1'b0;
      frame_done   = 1'b0;
      if (accept) begin
         if (st.sink_startofpacket) begin
            write_beat = 1'b1;
            err_set    = (state == IN_FRAME);
            if (st.sink_endofpacket) begin
               frame_done   = 1'b1;
               state_next   = IDLE;
               pix_cnt_next = '0;
               if (N_C != ONE_C) err_set = 1'b1;
            end else begin
               state_next   = IN_FRAME;
               pix_cnt_next = ONE_C;
            end
         end else if (state == IN_FRAME) begin
            write_beat = 1'b1;
            if (st.sink_endofpacket) begin
               frame_done   = 1'b1;
               err_set      = (pix_inc != N_C);
               state_next   = IDLE;
               pix_cnt_next = '0;
            end else if (pix_inc == N_C) begin
               err_set      = 1'b1;
               state_next   = IDLE;
               pix_cnt_next = '0;
            end else begin
               pix_cnt_next = pix_inc;
            end
         end else begin
            err_set = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
      if (sys_reset_reset) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         frame_count <= '0;
         frame_err   <= 1'b0;
      end else begin
         state   <= state_next;
         pix_cnt <= pix_cnt_next;
         if (frame_done) frame_count <= frame_count + 16'd1;
         if (err_set) frame_err <= 1'b1;
         else if (clear_err) frame_err <= 1'b0;
      end
   end

   // Pointers are AW bits wide so they wrap modulo the power-of-two depth.
   always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
      if (sys_reset_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge sys_clk_clk) begin
      if (push) mem[wr_ptr] <= {rgb, st.sink_startofpacket, st.sink_endofpacket};
   end
endmodule

// File: tb/tb_vga_pixel_rgb_resampler.sv
// Self-checking bench for vga_pixel_rgb_resampler with a 4x2 frame and an 8-deep FIFO.
// A frame-level reference model predicts the emitted beats, frame count and error flag.
module tb_vga_pixel_rgb_resampler;
   localparam int FW = 4;
   localparam int FH = 2;
   localparam int DEPTH = 8;
   localparam int NPIX = FW * FH;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_err = 1'b0;
   logic [15:0] frame_count;
   logic        frame_err;

   vga_pixel_rgb_resampler_if bus ();

   vga_pixel_rgb_resampler #(
      .FRAME_WIDTH (FW),
      .FRAME_HEIGHT(FH),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .sys_clk_clk    (clk),
      .sys_reset_reset(rst),
      .st             (bus),
      .frame_count    (frame_count),
      .frame_err      (frame_err),
      .clear_err      (clear_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   bit          rand_bp = 1'b0;
   logic [25:0] exp_q[$];
   logic [25:0] got_q[$];
   bit          m_in_frame = 1'b0;
   int          m_pix = 0;
   int          m_count = 0;
   bit          m_err = 1'b0;

   always @(posedge clk) begin
      if (!rst && bus.source_valid && bus.source_ready)
         got_q.push_back({bus.source_data, bus.source_startofpacket, bus.source_endofpacket});
   end

   function automatic logic [23:0] expand(input logic [15:0] p);
      int r = int'(p[15:11]);
      int g = int'(p[10:5]);
      int b = int'(p[4:0]);
      return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
   endfunction

   // Frame rules: a beat is kept if it opens a frame or lies inside one.
   task automatic modelAccept(input logic [15:0] d, input bit sop, input bit eop);
      bit wr = 1'b0;
      if (sop) begin
         if (m_in_frame) m_err = 1'b1;
         wr = 1'b1;
         m_pix = 1;
         m_in_frame = 1'b1;
      end else if (m_in_frame) begin
         wr = 1'b1;
         m_pix++;
      end else begin
         m_err = 1'b1;
      end
      if (wr && eop) begin
         m_count = (m_count + 1) % 65536;
         if (m_pix != NPIX) m_err = 1'b1;
         m_in_frame = 1'b0;
      end else if (wr && m_pix == NPIX) begin
         m_err = 1'b1;
         m_in_frame = 1'b0;
      end
      if (wr) exp_q.push_back({expand(d), sop, eop});
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic driveCycle(input logic [15:0] d, input bit sop, input bit eop, output bit acc);
      @(negedge clk);
      if (rand_bp) bus.source_ready = 1'($urandom_range(0, 1));
      bus.sink_data = d;
      bus.sink_startofpacket = sop;
      bus.sink_endofpacket = eop;
      bus.sink_valid = 1'b1;
      acc = bus.sink_ready;
      if (acc) modelAccept(d, sop, eop);
      @(posedge clk);
      #1;
      bus.sink_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [15:0] d, input bit sop, input bit eop);
      bit acc = 1'b0;
      int t = 0;
      while (!acc && t < 200) begin
         driveCycle(d, sop, eop, acc);
         t++;
      end
      checkOutput("sink_accept", 32'(acc), 32'd1);
   endtask

   task automatic sendFrame(input int len, input int eop_idx);
      for (int i = 0; i < len; i++)
         applyStimulus(16'($urandom), i == 0, i == eop_idx);
   endtask

   task automatic drainAndCompare(input string tag);
      int t = 0;
      int n;
      rand_bp = 1'b0;
      @(negedge clk);
      bus.source_ready = 1'b1;
      while ((got_q.size() < exp_q.size() || bus.source_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic checkStatus(input string tag);
      checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'(m_count));
      checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
   endtask

   initial begin
      bit          acc;
      int          idx;
      logic [15:0] sweep[8];
      bus.sink_data = '0;
      bus.sink_startofpacket = 1'b0;
      bus.sink_endofpacket = 1'b0;
      bus.sink_valid = 1'b0;
      bus.source_ready = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_sink_ready", 32'(bus.sink_ready), 32'd0);
      checkOutput("rst_source_valid", 32'(bus.source_valid), 32'd0);
      checkOutput("rst_source_data", 32'(bus.source_data), 32'd0);
      checkStatus("rst");
      rst = 1'b0;
      #1;
      checkOutput("post_rst_sink_ready", 32'(bus.sink_ready), 32'd1);

      // Nominal frame of red pixels; first output one cycle after accept.
      checkOutput("t1_idle_valid", 32'(bus.source_valid), 32'd0);
      applyStimulus(16'hF800, 1'b1, 1'b0);
      checkOutput("t1_first_valid", 32'(bus.source_valid), 32'd1);
      checkOutput("t1_first_data", 32'(bus.source_data), 32'hFF0000);
      checkOutput("t1_first_sop", 32'(bus.source_startofpacket), 32'd1);
      for (int i = 1; i < NPIX; i++) applyStimulus(16'hF800, 1'b0, i == NPIX - 1);
      drainAndCompare("t1");
      checkStatus("t1");

      // Backpressure: only DEPTH beats fit while the source is stalled.
      bus.source_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (idx < NPIX) driveCycle(16'($urandom), idx == 0, idx == NPIX - 1, acc);
         else driveCycle(16'($urandom), 1'b0, 1'b0, acc);
         if (acc) idx++;
      end
      checkOutput("bp_accepted", 32'(idx), 32'(DEPTH));
      checkOutput("bp_sink_ready", 32'(bus.sink_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("bp_head_stable", 32'({bus.source_data, bus.source_startofpacket,
                     bus.source_endofpacket}), 32'(exp_q[0]));
      end
      drainAndCompare("bp");
      checkStatus("bp");

      // Early eop on beat 5, then clear, then a clean frame.
      sendFrame(5, 4);
      drainAndCompare("early");
      checkStatus("early");
      @(negedge clk);
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      clear_err = 1'b0;
      m_err = 1'b0;
      checkStatus("clear");
      sendFrame(NPIX, NPIX - 1);
      drainAndCompare("clean");
      checkStatus("clean");

      // Orphan beats outside a frame are dropped and flagged.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(16'($urandom), 1'b0, i == 2);
         checkOutput("orphan_sink_ready", 32'(bus.sink_ready), 32'd1);
         checkOutput("orphan_source_valid", 32'(bus.source_valid), 32'd0);
      end
      checkStatus("orphan");
      sendFrame(NPIX, NPIX - 1);
      drainAndCompare("after_orphan");
      checkStatus("after_orphan");

      // Expansion sweep with randomized downstream stalls.
      sweep = '{16'h07E0, 16'h001F, 16'h8410, 16'hFFFF, 16'h0000, 16'hF800,
                16'($urandom), 16'($urandom)};
      rand_bp = 1'b1;
      for (int i = 0; i < NPIX; i++) applyStimulus(sweep[i], i == 0, i == NPIX - 1);
      drainAndCompare("sweep");
      checkStatus("sweep");

      // Reset mid-frame with four beats buffered.
      bus.source_ready = 1'b0;
      sendFrame(4, -1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      got_q.delete();
      m_in_frame = 1'b0;
      m_pix = 0;
      m_count = 0;
      m_err = 1'b0;
      checkOutput("midrst_source_valid", 32'(bus.source_valid), 32'd0);
      checkOutput("midrst_sink_ready", 32'(bus.sink_ready), 32'd0);
      checkStatus("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.source_ready = 1'b1;
      sendFrame(NPIX, NPIX - 1);
      drainAndCompare("post_rst");
      checkStatus("post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
